// File: rtl/mips_pkg.sv
// MIPS single-cycle core: shared opcodes, functs and control types.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  localparam logic [4:0] RA = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {
    DST_RT, DST_RD, DST_RA
  } dst_e;

  typedef struct packed {
    logic    reg_write;
    dst_e    dst;
    logic    alu_imm;
    logic    zext;
    logic    mem_write;
    logic    mem_to_reg;
    logic    beq;
    logic    bne;
    logic    jump;
    logic    link;
    logic    jr;
    alu_op_e alu_op;
  } ctrl_t;
endpackage

// File: rtl/mips_alu.sv
// MIPS ALU: arithmetic, logic, compares and shamt shifts.
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] res_o,
  output logic        zero_o
);
  always_comb begin
    res_o = '0;
    unique case (op_i)
      ALU_ADD:  res_o = a_i + b_i;
      ALU_SUB:  res_o = a_i - b_i;
      ALU_AND:  res_o = a_i & b_i;
      ALU_OR:   res_o = a_i | b_i;
      ALU_XOR:  res_o = a_i ^ b_i;
      ALU_NOR:  res_o = ~(a_i | b_i);
      ALU_SLT:  res_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: res_o = {31'b0, a_i < b_i};
      ALU_SLL:  res_o = b_i << shamt_i;
      ALU_SRL:  res_o = b_i >> shamt_i;
      ALU_SRA:  res_o = $unsigned($signed(b_i) >>> shamt_i);
      ALU_LUI:  res_o = {b_i[15:0], 16'h0000};
      default:  res_o = '0;
    endcase
  end

  assign zero_o = (res_o == 32'd0);
endmodule

// File: rtl/mips_units.sv
// MIPS core building blocks: PC, memories, register file, decoder.
module mips_pc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_d,
  output logic [31:0] OUT
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) OUT <= '0;
    else        OUT <= pc_d;
  end
endmodule

module mips_imem #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [31:0]   wd_i,
  input  logic [AW-1:0] ra_i,
  output logic [31:0]   rd_o
);
  logic [31:0] InstructionMemory [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we_i) InstructionMemory[wa_i] <= wd_i;
  end

  assign rd_o = InstructionMemory[ra_i];
endmodule

module mips_rf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] Registers [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) Registers[i] <= '0;
    end else if (we_i && wa_i != 5'd0) begin
      Registers[wa_i] <= wd_i;
    end
  end

  assign rd1_o = Registers[ra1_i];
  assign rd2_o = Registers[ra2_i];
endmodule

module mips_dm #(
  parameter int BYTES = 1024,
  parameter int AW    = $clog2(BYTES)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wd_i,
  output logic [31:0]   rd_o
);
  logic [7:0]    DataMemory [0:BYTES-1];
  logic [AW-1:0] a1, a2, a3;

  // byte lanes wrap around the end of memory
  assign a1 = addr_i + AW'(1);
  assign a2 = addr_i + AW'(2);
  assign a3 = addr_i + AW'(3);

  always_ff @(posedge clk) begin
    if (we_i) begin
      DataMemory[addr_i] <= wd_i[31:24];
      DataMemory[a1]     <= wd_i[23:16];
      DataMemory[a2]     <= wd_i[15:8];
      DataMemory[a3]     <= wd_i[7:0];
    end
  end

  assign rd_o = {DataMemory[addr_i], DataMemory[a1],
                 DataMemory[a2], DataMemory[a3]};
endmodule

module mips_ctrl
  import mips_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o
);
  always_comb begin
    ctrl_o.reg_write  = 1'b0;
    ctrl_o.dst        = DST_RT;
    ctrl_o.alu_imm    = 1'b0;
    ctrl_o.zext       = 1'b0;
    ctrl_o.mem_write  = 1'b0;
    ctrl_o.mem_to_reg = 1'b0;
    ctrl_o.beq        = 1'b0;
    ctrl_o.bne        = 1'b0;
    ctrl_o.jump       = 1'b0;
    ctrl_o.link       = 1'b0;
    ctrl_o.jr         = 1'b0;
    ctrl_o.alu_op     = ALU_ADD;
    unique case (op_i)
      OP_RTYPE: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.dst       = DST_RD;
        unique case (funct_i)
          F_ADD, F_ADDU: ctrl_o.alu_op = ALU_ADD;
          F_SUB, F_SUBU: ctrl_o.alu_op = ALU_SUB;
          F_AND:  ctrl_o.alu_op = ALU_AND;
          F_OR:   ctrl_o.alu_op = ALU_OR;
          F_XOR:  ctrl_o.alu_op = ALU_XOR;
          F_NOR:  ctrl_o.alu_op = ALU_NOR;
          F_SLT:  ctrl_o.alu_op = ALU_SLT;
          F_SLTU: ctrl_o.alu_op = ALU_SLTU;
          F_SLL:  ctrl_o.alu_op = ALU_SLL;
          F_SRL:  ctrl_o.alu_op = ALU_SRL;
          F_SRA:  ctrl_o.alu_op = ALU_SRA;
          F_JR: begin
            ctrl_o.reg_write = 1'b0;
            ctrl_o.jr        = 1'b1;
          end
          default: ctrl_o.reg_write = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_imm   = 1'b1;
      end
      OP_SLTI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_imm   = 1'b1;
        ctrl_o.alu_op    = ALU_SLT;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_imm   = 1'b1;
        ctrl_o.zext      = 1'b1;
        ctrl_o.alu_op    = (op_i == OP_ANDI) ? ALU_AND :
                           (op_i == OP_ORI)  ? ALU_OR : ALU_XOR;
      end
      OP_LUI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_imm   = 1'b1;
        ctrl_o.alu_op    = ALU_LUI;
      end
      OP_LW: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_imm    = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl_o.alu_imm   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.beq    = 1'b1;
        ctrl_o.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        ctrl_o.bne    = 1'b1;
        ctrl_o.alu_op = ALU_SUB;
      end
      OP_J:   ctrl_o.jump = 1'b1;
      OP_JAL: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.link      = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.dst       = DST_RA;
      end
      default: ctrl_o.reg_write = 1'b0;
    endcase
  end
endmodule

// File: rtl/mips_single_cycle.sv
// Single-cycle MIPS core: fetch, decode, execute and retire
// one instruction per clock with on-chip I/D memories.
module mips_single_cycle
  import mips_pkg::*;
#(
  parameter int IM_WORDS = 256,
  parameter int DM_BYTES = 1024
) (
  input logic clk,
  input logic rst_n
);
  localparam int IAW = $clog2(IM_WORDS);
  localparam int DAW = $clog2(DM_BYTES);

  logic [31:0] pc_q, pc_d, pc4, br_tgt;
  logic [31:0] instr, rs_val, rt_val;
  logic [31:0] imm_sext, imm_ext, alu_b;
  logic [31:0] alu_res, dm_rd, wd;
  logic [4:0]  wa;
  logic        zero, taken;
  ctrl_t       ctrl;

  mips_pc ProgCounter (
    .clk(clk), .rst_n(rst_n), .pc_d(pc_d), .OUT(pc_q)
  );

  mips_imem #(.WORDS(IM_WORDS)) IM (
    .clk(clk), .we_i(1'b0), .wa_i('0), .wd_i('0),
    .ra_i(pc_q[IAW+1:2]), .rd_o(instr)
  );

  mips_ctrl CTRL (
    .op_i(instr[31:26]), .funct_i(instr[5:0]), .ctrl_o(ctrl)
  );

  mips_rf RF (
    .clk(clk), .rst_n(rst_n),
    .ra1_i(instr[25:21]), .ra2_i(instr[20:16]),
    .we_i(ctrl.reg_write), .wa_i(wa), .wd_i(wd),
    .rd1_o(rs_val), .rd2_o(rt_val)
  );

  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_ext  = ctrl.zext ? {16'h0000, instr[15:0]} : imm_sext;
  assign alu_b    = ctrl.alu_imm ? imm_ext : rt_val;

  mips_alu ALU (
    .a_i(rs_val), .b_i(alu_b), .op_i(ctrl.alu_op),
    .shamt_i(instr[10:6]), .res_o(alu_res), .zero_o(zero)
  );

  mips_dm #(.BYTES(DM_BYTES)) DM (
    .clk(clk), .we_i(ctrl.mem_write),
    .addr_i(alu_res[DAW-1:0]), .wd_i(rt_val), .rd_o(dm_rd)
  );

  assign pc4    = pc_q + 32'd4;
  assign br_tgt = pc4 + {imm_sext[29:0], 2'b00};
  assign taken  = (ctrl.beq & zero) | (ctrl.bne & ~zero);

  always_comb begin
    pc_d = pc4;
    unique case (1'b1)
      ctrl.jr:   pc_d = rs_val;
      ctrl.jump: pc_d = {pc4[31:28], instr[25:0], 2'b00};
      taken:     pc_d = br_tgt;
      default:   pc_d = pc4;
    endcase
  end

  always_comb begin
    wa = instr[20:16];
    unique case (ctrl.dst)
      DST_RD:  wa = instr[15:11];
      DST_RA:  wa = RA;
      default: wa = instr[20:16];
    endcase
  end

  assign wd = ctrl.link       ? pc4   :
              ctrl.mem_to_reg ? dm_rd : alu_res;
endmodule

// File: tb/tb_mips_single_cycle.sv
// Bench for mips_single_cycle: directed programs plus random
// straight-line code checked against an ISA-level model.
module tb_mips_single_cycle;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errs = 0;

  localparam int ADD = 32, ADDU = 33, SUB = 34, SUBU = 35;
  localparam int AND_ = 36, OR_ = 37, XOR_ = 38, NOR_ = 39;
  localparam int SLT = 42, SLTU = 43, SLL = 0, SRL = 2, SRA = 3, JR = 8;
  localparam int ADDI = 8, ADDIU = 9, SLTI = 10, ANDI = 12;
  localparam int ORI = 13, XORI = 14, LUI = 15, LW = 35, SW = 43;
  localparam int BEQ = 4, BNE = 5, JAL = 3;
  localparam int T0 = 8, T1 = 9, T2 = 10, T3 = 11, T4 = 12, S0 = 16;

  localparam int RFN [10] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
  localparam int SFN [3]  = '{0, 2, 3};
  localparam int IOP [7]  = '{8, 9, 10, 12, 13, 14, 15};
  localparam int BADF [3] = '{1, 5, 63};
  localparam int BADO [3] = '{6, 7, 63};

  mips_single_cycle #(.IM_WORDS(256), .DM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(int fn, int rs, int rt,
                                        int rd, int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_ins(int op, int rs, int rt, int im);
    return {6'(op), 5'(rs), 5'(rt), 16'(im)};
  endfunction

  function automatic logic [31:0] j_ins(int op, int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  function automatic logic [31:0] pc_now();
    return dut.ProgCounter.OUT;
  endfunction

  function automatic logic [31:0] rf(int i);
    return dut.RF.Registers[5'(i)];
  endfunction

  function automatic logic [31:0] dm_word(int a);
    logic [9:0] e;
    e = 10'(a);
    return {dut.DM.DataMemory[e], dut.DM.DataMemory[e + 10'd1],
            dut.DM.DataMemory[e + 10'd2], dut.DM.DataMemory[e + 10'd3]};
  endfunction

  function automatic logic [31:0] rf_or();
    logic [31:0] acc = '0;
    for (int i = 0; i < 32; i++) acc |= dut.RF.Registers[5'(i)];
    return acc;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [31:0] prog[$]);
    for (int i = 0; i < 256; i++)
      dut.IM.InstructionMemory[8'(i)] = (i < prog.size()) ? prog[i] : 32'h0;
  endtask

  // Reset held across a program load, released on a falling edge.
  task automatic boot(input logic [31:0] prog[$]);
    @(negedge clk);
    rst_n = 1'b0;
    load(prog);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---- ISA-level reference model ----
  logic [31:0] m_reg [32];
  logic [7:0]  m_mem [1024];
  bit          m_val [1024];
  logic [31:0] stored [$];

  task automatic m_exec(input logic [31:0] ins);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] a, b, sx, zx, v;
    logic [9:0]  e;
    int dst;
    op = ins[31:26]; fn = ins[5:0];
    rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
    a = m_reg[rs]; b = m_reg[rt];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    e = 10'(a + sx);
    v = '0;
    dst = -1;
    case (int'(op))
      0: begin
        dst = int'(rd);
        case (int'(fn))
          ADD, ADDU: v = a + b;
          SUB, SUBU: v = a - b;
          AND_: v = a & b;
          OR_:  v = a | b;
          XOR_: v = a ^ b;
          NOR_: v = ~(a | b);
          SLT:  v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          SLTU: v = (a < b) ? 32'd1 : 32'd0;
          SLL:  v = b << sh;
          SRL:  v = b >> sh;
          SRA:  v = $signed(b) >>> sh;
          default: dst = -1;
        endcase
      end
      ADDI, ADDIU: begin dst = int'(rt); v = a + sx; end
      SLTI: begin
        dst = int'(rt);
        v = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
      end
      ANDI: begin dst = int'(rt); v = a & zx; end
      ORI:  begin dst = int'(rt); v = a | zx; end
      XORI: begin dst = int'(rt); v = a ^ zx; end
      LUI:  begin dst = int'(rt); v = {ins[15:0], 16'h0}; end
      LW: begin
        dst = int'(rt);
        v = {m_mem[e], m_mem[e + 10'd1], m_mem[e + 10'd2], m_mem[e + 10'd3]};
      end
      SW: begin
        for (int k = 0; k < 4; k++) begin
          m_mem[e + 10'(k)] = b[31 - 8*k -: 8];
          m_val[e + 10'(k)] = 1'b1;
        end
      end
      default: dst = -1;
    endcase
    if (dst > 0) m_reg[dst] = v;
  endtask

  task automatic gen_one(output logic [31:0] ins);
    int kind, rs, rt, rd, sh, im;
    logic [31:0] ea;
    kind = $urandom_range(0, 9);
    rs = $urandom_range(0, 15);
    rt = $urandom_range(0, 15);
    rd = $urandom_range(0, 15);
    sh = $urandom_range(0, 31);
    im = $urandom_range(0, 65535);
    ins = 32'h0;
    if (kind <= 2) begin
      ins = r_ins(RFN[4'($urandom_range(0, 9))], rs, rt, rd, 0);
    end else if (kind == 3) begin
      ins = r_ins(SFN[2'($urandom_range(0, 2))], 0, rt, rd, sh);
    end else if (kind <= 5) begin
      ins = i_ins(IOP[3'($urandom_range(0, 6))], rs, rt, im);
    end else if (kind == 6) begin
      im = $urandom_range(0, 1023);
      ins = i_ins(SW, rs, rt, im);
      ea = (m_reg[rs] + 32'(im)) & 32'h3ff;
      stored.push_back(ea);
    end else if (kind <= 8) begin
      if (stored.size() > 0) begin
        ea = stored[$urandom_range(0, stored.size() - 1)];
        im = int'((ea - m_reg[rs]) & 32'h3ff);
        ins = i_ins(LW, rs, rt, im);
      end
    end else if ($urandom_range(0, 1) == 0) begin
      ins = r_ins(BADF[2'($urandom_range(0, 2))], rs, rt, rd, sh);
    end else begin
      ins = i_ins(BADO[2'($urandom_range(0, 2))], rs, rt, im);
    end
    m_exec(ins);
  endtask

  initial begin
    logic [31:0] prog [$];
    logic [31:0] ins;
    int k;

    // reset and $0
    prog = '{i_ins(ADDI, 0, 0, 5)};
    @(negedge clk);
    load(prog);
    #1;
    check("rst_pc", pc_now(), 32'd0);
    check("rst_regs", rf_or(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("pc_at_release", pc_now(), 32'd0);
    step(1);
    check("pc_after_1", pc_now(), 32'd4);
    check("r0_stays_0", rf(0), 32'd0);

    // arithmetic
    prog = '{i_ins(ADDI, 0, T0, -1), i_ins(ADDIU, 0, T1, 1),
             r_ins(ADD, T0, T1, T2, 0), r_ins(SLTU, T1, T0, T3, 0),
             r_ins(SLT, T1, T0, T4, 0)};
    boot(prog);
    step(5);
    check("arith_t0", rf(T0), 32'hffff_ffff);
    check("arith_t2", rf(T2), 32'd0);
    check("arith_t3", rf(T3), 32'd1);
    check("arith_t4", rf(T4), 32'd0);

    // memory, big-endian
    prog = '{i_ins(ORI, 0, T0, 16'h1234), i_ins(LUI, 0, T1, 16'habcd),
             r_ins(OR_, T1, T0, T1, 0), i_ins(SW, 0, T1, 8),
             i_ins(LW, 0, T2, 8)};
    boot(prog);
    step(5);
    check("dm8", 32'(dut.DM.DataMemory[8]), 32'hab);
    check("dm9", 32'(dut.DM.DataMemory[9]), 32'hcd);
    check("dm10", 32'(dut.DM.DataMemory[10]), 32'h12);
    check("dm11", 32'(dut.DM.DataMemory[11]), 32'h34);
    check("mem_t2", rf(T2), 32'habcd1234);

    // array sum: fill 1..10, then sum and store at byte 40
    prog = '{i_ins(ADDI, 0, T0, 1), i_ins(ADDI, 0, T1, 0),
             i_ins(ADDI, 0, T2, 40), i_ins(SW, T1, T0, 0),
             i_ins(ADDI, T0, T0, 1), i_ins(ADDI, T1, T1, 4),
             i_ins(BNE, T1, T2, -4), i_ins(ADDI, 0, S0, 0),
             i_ins(ADDI, 0, T1, 0), i_ins(LW, T1, T3, 0),
             r_ins(ADD, S0, T3, S0, 0), i_ins(ADDI, T1, T1, 4),
             i_ins(BNE, T1, T2, -4), i_ins(SW, 0, S0, 40),
             i_ins(BEQ, 0, 0, -1)};
    boot(prog);
    k = 0;
    while (pc_now() != 32'd52 && k < 300) begin
      step(1);
      k++;
    end
    check("sum_loop_exit_pc", pc_now(), 32'd52);
    step(1);
    check("sum_word10", dm_word(40), 32'h37);
    check("sum_s0", rf(S0), 32'h37);
    for (int i = 0; i < 10; i++)
      check($sformatf("arr_w%0d", i), dm_word(4 * i), 32'(i + 1));
    step(3);
    check("halt_pc", pc_now(), 32'd56);

    // async reset between edges mid-loop
    boot(prog);
    step(60);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pc", pc_now(), 32'd0);
    check("midrst_regs", rf_or(), 32'd0);
    for (int i = 0; i < 10; i++)
      check($sformatf("midrst_w%0d", i), dm_word(4 * i), 32'(i + 1));
    check("midrst_w10", dm_word(40), 32'h37);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check("midrst_restart_pc", pc_now(), 32'd4);

    // jal / jr / beq not taken
    prog = '{i_ins(ADDI, 0, T0, 7), 32'h0, 32'h0, 32'h0,
             j_ins(JAL, 32'h10), i_ins(ADDI, 0, T1, 3),
             i_ins(BEQ, T0, T1, 5), i_ins(BEQ, 0, 0, -1),
             32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
             i_ins(ADDI, 0, T2, 1), r_ins(JR, 31, 0, 0, 0)};
    boot(prog);
    step(4);
    check("pre_jal_pc", pc_now(), 32'h10);
    step(1);
    check("jal_pc", pc_now(), 32'h40);
    check("jal_ra", rf(31), 32'h14);
    step(2);
    check("jr_pc", pc_now(), 32'h14);
    check("sub_t2", rf(T2), 32'd1);
    step(2);
    check("beq_nt_pc", pc_now(), 32'h1c);
    check("beq_nt_t1", rf(T1), 32'd3);

    // random straight-line programs against the model
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < 32; r++) m_reg[r] = '0;
      prog = {};
      for (int n = 0; n < 64; n++) begin
        gen_one(ins);
        prog.push_back(ins);
      end
      boot(prog);
      step(64);
      check($sformatf("rnd%0d_pc", it), pc_now(), 32'd256);
      for (int r = 0; r < 32; r++)
        check($sformatf("rnd%0d_r%0d", it, r), rf(r), m_reg[r]);
      foreach (stored[s])
        check($sformatf("rnd%0d_dm%0d", it, stored[s]),
              dm_word(int'(stored[s])),
              {m_mem[10'(stored[s])], m_mem[10'(stored[s] + 1)],
               m_mem[10'(stored[s] + 2)], m_mem[10'(stored[s] + 3)]});
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end
endmodule
